// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch/timer controller: prescaled tick, up/down count with preset,
// lap-freeze display hold and an EXPIRED state with alarm/wrap pulses.
module stopwatch_timer_ctrl #(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             mode,
  input  logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] disp_count,
  output logic [2:0]       status,
  output logic             count_enable,
  output logic             tick,
  output logic             alarm,
  output logic             wrap
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_RUNNING = 3'b001,
    S_PAUSED  = 3'b010,
    S_LAP     = 3'b011,
    S_EXPIRED = 3'b100
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] freeze_q;
  logic [DIV_W-1:0] div_q;
  logic             mode_q;
  logic             alarm_q;
  logic             wrap_q;

  logic enable_s;
  logic tick_s;
  logic expire_s;
  logic start_go_s;
  logic lap_go_s;

  assign enable_s   = (state_q == S_RUNNING) || (state_q == S_LAP);
  assign tick_s     = enable_s && (div_q == DIV_MAX);
  assign expire_s   = tick_s && mode_q && (count_q == CNT_ONE);
  // start loses to a simultaneous stop; lap loses to either
  assign start_go_s = start && !stop;
  assign lap_go_s   = lap && !stop && !start;

  // Single FSM: state, prescaler, count, freeze register and output pulses
  always_ff @(posedge clk) begin
    alarm_q <= 1'b0;
    wrap_q  <= 1'b0;
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      freeze_q <= '0;
      div_q    <= '0;
      mode_q   <= 1'b0;
    end else if (clear) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      freeze_q <= '0;
      div_q    <= '0;
    end else begin
      if (tick_s) begin
        div_q <= '0;
        if (mode_q) begin
          count_q <= count_q - CNT_ONE;
        end else begin
          count_q <= count_q + CNT_ONE;
          wrap_q  <= (count_q == CNT_MAX);
        end
      end else if (enable_s) begin
        div_q <= div_q + DIV_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start_go_s) begin
            mode_q <= mode;
            div_q  <= '0;
            if (mode && (preset == '0)) begin
              state_q <= S_EXPIRED;
              count_q <= '0;
              alarm_q <= 1'b1;
            end else begin
              state_q <= S_RUNNING;
              count_q <= mode ? preset : '0;
            end
          end
        end
        S_RUNNING: begin
          if (expire_s) begin
            state_q <= S_EXPIRED;
            alarm_q <= 1'b1;
          end else if (stop) begin
            state_q <= S_PAUSED;
          end else if (lap_go_s) begin
            state_q  <= S_LAP;
            freeze_q <= count_q;
          end
        end
        S_LAP: begin
          if (expire_s) begin
            state_q <= S_EXPIRED;
            alarm_q <= 1'b1;
          end else if (stop) begin
            state_q <= S_PAUSED;
          end else if (lap_go_s) begin
            state_q <= S_RUNNING;
          end
        end
        S_PAUSED: begin
          if (start_go_s) begin
            state_q <= S_RUNNING;
          end
        end
        S_EXPIRED: begin
          // restart keeps the latched down mode and reloads the live preset
          if (start_go_s) begin
            div_q <= '0;
            if (preset == '0) begin
              count_q <= '0;
              alarm_q <= 1'b1;
            end else begin
              state_q <= S_RUNNING;
              count_q <= preset;
            end
          end else begin
            count_q <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          count_q <= '0;
          div_q   <= '0;
        end
      endcase
    end
  end

  assign count        = count_q;
  assign disp_count   = (state_q == S_LAP) ? freeze_q : count_q;
  assign status       = state_q;
  assign count_enable = enable_s;
  assign tick         = tick_s;
  assign alarm        = alarm_q;
  assign wrap         = wrap_q;

endmodule
